// File: rtl/mem_port_seq_pkg.sv
// Shared types for the data-memory port sequencer.
// Only when MEM_TIMEOUT_EN is defined is the watchdog width used by hardware.
package mem_port_seq_pkg;

  localparam int unsigned LC3B_MEMSEQ_TO_W = 8;
  localparam int unsigned DATA_W           = 16;
  localparam int unsigned MASK_W           = 2;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    PTR    = 2'd1,
    ACCESS = 2'd2,
    DONE   = 2'd3
  } lc3b_memseq_state;

  // Transaction captured from the MEM stage at acceptance
  typedef struct packed {
    logic              rd;
    logic              ind;
    logic [DATA_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic [MASK_W-1:0] wmask;
  } memseq_req_t;

  // Memory-side command as presented on the mem_* pins
  typedef struct packed {
    logic              rd;
    logic              wr;
    logic [MASK_W-1:0] wmask;
    logic [DATA_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
  } mem_cmd_t;

  // Pointer fetch: a plain read of the request address
  function automatic mem_cmd_t ptr_cmd(input logic [DATA_W-1:0] addr);
    mem_cmd_t c;
    c       = '0;
    c.rd    = 1'b1;
    c.addr  = addr;
    return c;
  endfunction

  // Real access: indirect requests go to the fetched pointer, bit 0 untouched
  function automatic mem_cmd_t access_cmd(input memseq_req_t r,
                                          input logic [DATA_W-1:0] ptr);
    mem_cmd_t c;
    c.rd    = r.rd;
    c.wr    = ~r.rd;
    c.wmask = r.rd ? MASK_W'(0) : r.wmask;
    c.addr  = r.ind ? ptr : r.addr;
    c.wdata = r.wdata;
    return c;
  endfunction

endpackage

// File: rtl/mem_port_seq_if.sv
// Bus interfaces: MEM-stage request side and data-memory side.
interface mem_port_seq_if;
  import mem_port_seq_pkg::*;

  logic              read_b;
  logic              write_b;
  logic              indirect;
  logic [MASK_W-1:0] wmask_b;
  logic [DATA_W-1:0] address_b;
  logic [DATA_W-1:0] wdata_b;
  logic              resp_b;
  logic [DATA_W-1:0] rdata_b;

  modport master (output read_b, write_b, indirect, wmask_b, address_b, wdata_b,
                  input  resp_b, rdata_b);
  modport slave  (input  read_b, write_b, indirect, wmask_b, address_b, wdata_b,
                  output resp_b, rdata_b);
endinterface

interface mem_port_seq_mem_if;
  import mem_port_seq_pkg::*;

  logic              mem_read;
  logic              mem_write;
  logic [MASK_W-1:0] mem_wmask;
  logic [DATA_W-1:0] mem_address;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_resp;
  logic [DATA_W-1:0] mem_rdata;

  modport master (output mem_read, mem_write, mem_wmask, mem_address, mem_wdata,
                  input  mem_resp, mem_rdata);
  modport slave  (input  mem_read, mem_write, mem_wmask, mem_address, mem_wdata,
                  output mem_resp, mem_rdata);
endinterface

// File: rtl/mem_port_seq_timer.sv
// Watchdog counter with sticky error flag; exists only with MEM_TIMEOUT_EN.
`ifdef MEM_TIMEOUT_EN
module mem_seq_timer
  import mem_port_seq_pkg::*;
#(
  parameter logic [LC3B_MEMSEQ_TO_W-1:0] LIMIT = '1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear_i,
  input  logic tick_i,
  output logic expire_c,
  output logic timeout_err_o
);

  logic [LC3B_MEMSEQ_TO_W-1:0] cnt_q;
  logic                        err_q;

  // Expires on the cycle that would bring the count up to LIMIT
  assign expire_c      = tick_i && ((cnt_q + LC3B_MEMSEQ_TO_W'(1)) == LIMIT);
  assign timeout_err_o = err_q;

  // Count waiting cycles; flag stays set until reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q <= '0;
      err_q <= 1'b0;
    end else begin
      if (clear_i) begin
        cnt_q <= '0;
      end else if (tick_i) begin
        cnt_q <= cnt_q + LC3B_MEMSEQ_TO_W'(1);
      end
      if (expire_c) begin
        err_q <= 1'b1;
      end
    end
  end

endmodule
`endif

// File: rtl/mem_port_seq.sv
// Data-memory port sequencer: single access or LDI/STI pointer-then-access.
// Optional watchdog enabled by defining MEM_TIMEOUT_EN.
module mem_port_seq
  import mem_port_seq_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic               clk,
  input  logic               rst_n,
  mem_port_seq_if.slave      up,
  mem_port_seq_mem_if.master mem,
  output logic               timeout_err
);

  lc3b_memseq_state  state_q;
  memseq_req_t       req_q;
  mem_cmd_t          cmd_q;
  logic [DATA_W-1:0] ptr_q;
  logic [DATA_W-1:0] rdata_q;
  logic              resp_q;
  memseq_req_t       req_in_c;
  logic              timeout_c;

  // Request as it would be latched this cycle; read wins over write
  assign req_in_c = '{rd:    up.read_b,
                      ind:   up.indirect,
                      addr:  up.address_b,
                      wdata: up.wdata_b,
                      wmask: up.wmask_b};

`ifdef MEM_TIMEOUT_EN
  logic timer_clear_c;
  logic timer_tick_c;

  // Restart on every entry into PTR/ACCESS, count while waiting on memory
  assign timer_clear_c = (state_q == IDLE) || (state_q == DONE) ||
                         ((state_q == PTR) && mem.mem_resp);
  assign timer_tick_c  = ((state_q == PTR) || (state_q == ACCESS)) && !mem.mem_resp;

  mem_seq_timer #(
    .LIMIT(LC3B_MEMSEQ_TO_W'(TIMEOUT_CYCLES))
  ) u_timer (
    .clk          (clk),
    .rst_n        (rst_n),
    .clear_i      (timer_clear_c),
    .tick_i       (timer_tick_c),
    .expire_c     (timeout_c),
    .timeout_err_o(timeout_err)
  );
`else
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = ^(LC3B_MEMSEQ_TO_W'(TIMEOUT_CYCLES));
  assign timeout_c          = 1'b0;
  assign timeout_err        = 1'b0;
`endif

  // Sequencer FSM; every pin-level output is a flop updated here
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      req_q   <= '0;
      cmd_q   <= '0;
      ptr_q   <= '0;
      rdata_q <= '0;
      resp_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (up.read_b || up.write_b) begin
            req_q <= req_in_c;
            if (up.indirect) begin
              state_q <= PTR;
              cmd_q   <= ptr_cmd(up.address_b);
            end else begin
              state_q <= ACCESS;
              cmd_q   <= access_cmd(req_in_c, DATA_W'(0));
            end
          end
        end
        PTR: begin
          if (mem.mem_resp) begin
            ptr_q   <= mem.mem_rdata;
            state_q <= ACCESS;
            cmd_q   <= access_cmd(req_q, mem.mem_rdata);
          end else if (timeout_c) begin
            state_q <= DONE;
            cmd_q   <= '0;
            rdata_q <= '0;
            resp_q  <= 1'b1;
          end else begin
            cmd_q   <= ptr_cmd(req_q.addr);
          end
        end
        ACCESS: begin
          if (mem.mem_resp) begin
            state_q <= DONE;
            cmd_q   <= '0;
            rdata_q <= mem.mem_rdata;
            resp_q  <= 1'b1;
          end else if (timeout_c) begin
            state_q <= DONE;
            cmd_q   <= '0;
            rdata_q <= '0;
            resp_q  <= 1'b1;
          end else begin
            cmd_q   <= access_cmd(req_q, ptr_q);
          end
        end
        DONE: begin
          state_q <= IDLE;
          resp_q  <= 1'b0;
          rdata_q <= '0;
        end
        default: begin
          state_q <= IDLE;
          cmd_q   <= '0;
          resp_q  <= 1'b0;
          rdata_q <= '0;
        end
      endcase
    end
  end

  assign up.resp_b       = resp_q;
  assign up.rdata_b      = rdata_q;
  assign mem.mem_read    = cmd_q.rd;
  assign mem.mem_write   = cmd_q.wr;
  assign mem.mem_wmask   = cmd_q.wmask;
  assign mem.mem_address = cmd_q.addr;
  assign mem.mem_wdata   = cmd_q.wdata;

endmodule

// File: tb/tb_mem_port_seq.sv
// Directed bench for mem_port_seq; the watchdog section follows MEM_TIMEOUT_EN.
module tb_mem_port_seq;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  logic timeout_err;
  int   n_chk  = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;

  mem_port_seq_if     up_if ();
  mem_port_seq_mem_if mem_if ();

  mem_port_seq #(.TIMEOUT_CYCLES(4)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .up         (up_if),
    .mem        (mem_if),
    .timeout_err(timeout_err)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic idle_inputs();
    up_if.read_b    = 1'b0;
    up_if.write_b   = 1'b0;
    up_if.indirect  = 1'b0;
    up_if.wmask_b   = 2'b00;
    up_if.address_b = 16'h0000;
    up_if.wdata_b   = 16'h0000;
    mem_if.mem_resp  = 1'b0;
    mem_if.mem_rdata = 16'h0000;
  endtask

  // Every output low: {resp, rdata, read, write, wmask, addr, wdata}
  task automatic chk_quiet(input string tag);
    chk(tag, {up_if.resp_b, up_if.rdata_b, mem_if.mem_read, mem_if.mem_write,
              mem_if.mem_wmask, mem_if.mem_address, mem_if.mem_wdata}, 64'h0);
  endtask

  // One transaction with the bench acting as memory with latencies k1/k2
  task automatic run_txn(input string tag, input bit rd, input bit both, input bit ind,
                         input logic [15:0] addr, input logic [15:0] wdata,
                         input logic [1:0] wmask, input logic [15:0] ptr, input int k1,
                         input logic [15:0] data, input int k2);
    logic [15:0] acc_addr;
    bit          scrambled;
    acc_addr  = ind ? ptr : addr;
    scrambled = 1'b0;
    @(negedge clk);
    up_if.read_b    = rd;
    up_if.write_b   = !rd || both;
    up_if.indirect  = ind;
    up_if.address_b = addr;
    up_if.wdata_b   = wdata;
    up_if.wmask_b   = wmask;
    if (ind) begin
      for (int i = 0; i <= k1; i++) begin
        @(negedge clk);
        mem_if.mem_resp = 1'b0;
        if (!scrambled) begin
          up_if.address_b = ~addr;
          up_if.wdata_b   = ~wdata;
          up_if.wmask_b   = ~wmask;
          up_if.indirect  = 1'b0;
          scrambled       = 1'b1;
        end
        chk({tag, ".ptr"}, {up_if.resp_b, mem_if.mem_read, mem_if.mem_write,
                            mem_if.mem_address}, {1'b0, 1'b1, 1'b0, addr});
        if (i == k1) begin
          mem_if.mem_resp  = 1'b1;
          mem_if.mem_rdata = ptr;
        end
      end
    end
    for (int i = 0; i <= k2; i++) begin
      @(negedge clk);
      mem_if.mem_resp = 1'b0;
      if (!scrambled) begin
        up_if.address_b = ~addr;
        up_if.wdata_b   = ~wdata;
        up_if.wmask_b   = ~wmask;
        up_if.indirect  = 1'b1;
        scrambled       = 1'b1;
      end
      chk({tag, ".acc"}, {up_if.resp_b, mem_if.mem_read, mem_if.mem_write, mem_if.mem_wmask,
                          mem_if.mem_address, mem_if.mem_wdata},
          {1'b0, rd, !rd, (rd ? 2'b00 : wmask), acc_addr, wdata});
      if (i == k2) begin
        mem_if.mem_resp  = 1'b1;
        mem_if.mem_rdata = data;
      end
    end
    @(negedge clk);
    mem_if.mem_resp  = 1'b0;
    mem_if.mem_rdata = 16'h0000;
    chk({tag, ".resp"}, {up_if.resp_b, up_if.rdata_b, mem_if.mem_read, mem_if.mem_write},
        {1'b1, data, 1'b0, 1'b0});
    idle_inputs();
    @(negedge clk);
    chk({tag, ".after"}, {up_if.resp_b, up_if.rdata_b}, 64'h0);
  endtask

  initial begin
    idle_inputs();
    repeat (2) @(negedge clk);
    chk_quiet("reset_outputs");
    chk("reset_timeout_err", 64'(timeout_err), 64'h0);
    rst_n = 1'b1;

    // Stray memory response in IDLE must not start anything
    @(negedge clk);
    mem_if.mem_resp  = 1'b1;
    mem_if.mem_rdata = 16'hFFFF;
    @(negedge clk);
    mem_if.mem_resp  = 1'b0;
    chk_quiet("idle_stray_resp");
    @(negedge clk);
    chk_quiet("idle_stray_resp2");

    //      tag        rd  both ind  addr      wdata     mask   ptr       k1 data      k2
    run_txn("rd_direct", 1, 0, 0, 16'h3000, 16'h0000, 2'b00, 16'h0000, 0, 16'hBEEF, 2);
    run_txn("wr_direct", 0, 0, 0, 16'h4001, 16'h00AB, 2'b10, 16'h0000, 0, 16'h7777, 1);
    run_txn("ldi",       1, 0, 1, 16'h1000, 16'h0000, 2'b00, 16'h2000, 0, 16'h1234, 0);
    run_txn("sti",       0, 0, 1, 16'h1000, 16'h5555, 2'b11, 16'h2002, 1, 16'h0000, 0);
    run_txn("rd_wins",   1, 1, 0, 16'h0A0A, 16'hC0DE, 2'b01, 16'h0000, 0, 16'h4242, 0);
    run_txn("ldi_odd",   1, 0, 1, 16'h00FE, 16'h0000, 2'b00, 16'h2003, 2, 16'h9876, 1);

    // Reset while an access is outstanding drops it without a response
    @(negedge clk);
    up_if.read_b    = 1'b1;
    up_if.address_b = 16'h5000;
    @(negedge clk);
    chk("rst_mid.pre", {mem_if.mem_read, mem_if.mem_address}, {1'b1, 16'h5000});
    rst_n = 1'b0;
    @(negedge clk);
    chk_quiet("rst_mid.post");
    rst_n = 1'b1;
    idle_inputs();
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk_quiet("rst_mid.no_resp");
    end
    run_txn("after_rst", 1, 0, 0, 16'h5000, 16'h0000, 2'b00, 16'h0000, 0, 16'h1111, 0);

`ifndef MEM_TIMEOUT_EN
    // Without the watchdog the block waits as long as memory takes
    @(negedge clk);
    up_if.read_b    = 1'b1;
    up_if.address_b = 16'h6000;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      chk("no_wd.wait", {mem_if.mem_read, up_if.resp_b, timeout_err}, {1'b1, 1'b0, 1'b0});
    end
    mem_if.mem_resp  = 1'b1;
    mem_if.mem_rdata = 16'h0F0F;
    @(negedge clk);
    mem_if.mem_resp = 1'b0;
    chk("no_wd.resp", {up_if.resp_b, up_if.rdata_b, timeout_err}, {1'b1, 16'h0F0F, 1'b0});
    idle_inputs();
`else
    // Watchdog fires after four unanswered ACCESS cycles
    @(negedge clk);
    up_if.read_b    = 1'b1;
    up_if.address_b = 16'h6000;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("wd.wait", {mem_if.mem_read, up_if.resp_b, timeout_err}, {1'b1, 1'b0, 1'b0});
    end
    @(negedge clk);
    chk("wd.fire", {up_if.resp_b, up_if.rdata_b, mem_if.mem_read, timeout_err},
        {1'b1, 16'h0000, 1'b0, 1'b1});
    idle_inputs();
    run_txn("wd.next", 1, 0, 0, 16'h6100, 16'h0000, 2'b00, 16'h0000, 0, 16'h2222, 0);
    chk("wd.sticky", 64'(timeout_err), 64'h1);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    chk("wd.cleared", 64'(timeout_err), 64'h0);
    // Timeout during the pointer fetch skips the access entirely
    @(negedge clk);
    up_if.read_b    = 1'b1;
    up_if.indirect  = 1'b1;
    up_if.address_b = 16'h7000;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("wd_ptr.wait", {mem_if.mem_read, mem_if.mem_address, up_if.resp_b},
          {1'b1, 16'h7000, 1'b0});
    end
    @(negedge clk);
    chk("wd_ptr.fire", {up_if.resp_b, up_if.rdata_b, mem_if.mem_read, timeout_err},
        {1'b1, 16'h0000, 1'b0, 1'b1});
    idle_inputs();
`endif

    @(negedge clk);
    chk_quiet("final_idle");
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_port_seq.md
# mem_port_seq

Data-memory port sequencer between the MEM stage (`mem_datapath`) and the data memory/cache. It accepts the MEM stage's single-access request and turns indirect operations (LDI/STI) into a pointer read followed by the real access. It keeps every memory-side request registered and stable until `mem_resp`. It returns a one-cycle `resp_b` with read data, which releases the MEM-stage stall.

## Interface
- `TIMEOUT_CYCLES`, default 255: watchdog limit in cycles per memory access. Used only with `MEM_TIMEOUT_EN`; width 8 bits, legal range 1–255.
- `clk` in 1: clock; all logic is on the rising edge.
- `rst_n` in 1: reset, synchronous and active-low.
- `read_b` in 1: MEM-stage read request.
- `write_b` in 1: MEM-stage write request.
- `indirect` in 1: request is LDI/STI. Sampled only when the request is accepted.
- `wmask_b` in 2: byte enables for writes.
- `address_b` in 16: request address. For indirect requests this is the pointer address.
- `wdata_b` in 16: write data.
- `resp_b` out 1: request complete; a one-cycle pulse.
- `rdata_b` out 16: final read data; valid while `resp_b`=1.
- `mem_read` out 1: memory read strobe.
- `mem_write` out 1: memory write strobe.
- `mem_wmask` out 2: memory byte enables.
- `mem_address` out 16: memory address.
- `mem_wdata` out 16: memory write data.
- `mem_resp` in 1: memory completion, asserted for one cycle.
- `mem_rdata` in 16: memory read data; valid with `mem_resp`.
- `timeout_err` out 1: sticky watchdog flag. Tied 0 without `MEM_TIMEOUT_EN`.

## Operation
- States: IDLE, PTR, ACCESS, DONE.
- **IDLE**
  - All `mem_*` strobes are 0.
  - If `read_b|write_b`, latch `address_b`, `wdata_b`, `wmask_b`, `indirect` and the op (read when `read_b`, otherwise write).
  - Next state is PTR if `indirect`=1, else ACCESS.
  - If `read_b` and `write_b` are both 1, read wins.
- **PTR**
  - Drive `mem_read`=1, `mem_write`=0, `mem_address`=latched address.
  - On `mem_resp`: latch `ptr_q`=`mem_rdata`, go to ACCESS.
- **ACCESS**
  - Drive the latched op.
  - `mem_address` = `ptr_q` if indirect, else the latched address.
  - `mem_wdata` and `mem_wmask` come from the latches. `mem_wmask`=2'b00 on reads.
  - On `mem_resp`: `rdata_q`=`mem_rdata` (captured for writes too), go to DONE.
- **DONE**
  - `resp_b`=1 and `rdata_b`=`rdata_q` for exactly one cycle.
  - No memory strobes. Next state is always IDLE.
- `rdata_b` reads 0 outside DONE.
- Pointer bit 0 is passed unmodified; alignment is the memory's responsibility.
- Upstream holds its request stable while `resp_b`=0; this is guaranteed by the MEM-stage stall.
  - Changes to the request after acceptance are ignored; the latched transaction completes.
  - A request still asserted during DONE is not re-accepted. It is re-evaluated in IDLE on the next cycle, which is when the MEM stage has already advanced.
- `mem_resp` arriving in IDLE or DONE is ignored.

## Timing
- All `mem_*` outputs and `resp_b`/`rdata_b` are registered. No combinational path from any input to any output.
- Memory-side outputs are a function of state plus latches and are stable from entry into PTR/ACCESS until the cycle after `mem_resp`.
- Direct access:
  - Request seen in IDLE at cycle T.
  - `mem_*` driven from T+1.
  - `mem_resp` at T+1+k, with k≥0.
  - `resp_b` at T+2+k.
  - Minimum latency is 2 cycles.
- Indirect access: pointer read at T+1, `mem_resp` at T+1+k1, access driven from T+2+k1, `resp_b` at T+3+k1+k2. Minimum latency is 3 cycles.
- Back-to-back requests: IDLE is visited for at least one cycle between requests.
- Reset values: state=IDLE; every output 0; `ptr_q`, `rdata_q` and all latches 0.
- Reset mid-transaction: the transaction is dropped with no `resp_b`; the memory strobes fall in the cycle after `rst_n` is sampled low.

## Configuration
- Macro: `MEM_TIMEOUT_EN`.
- Defined:
  - An 8-bit counter clears on entry to PTR/ACCESS and increments each cycle in those states without `mem_resp`.
  - When the count reaches `TIMEOUT_CYCLES`, the block sets `timeout_err` (sticky until reset) and goes directly to DONE with `rdata_q`=16'h0000, so the pipeline cannot hang.
  - An indirect request that times out in PTR also skips ACCESS.
- Undefined: no counter; `timeout_err` is tied to 0; the block waits indefinitely for `mem_resp`.

## Structure
- `lc3b_types` gains `lc3b_memseq_state` (enum IDLE/PTR/ACCESS/DONE) and the constant `LC3B_MEMSEQ_TO_W`=8.
- One sub-module, `mem_seq_timer` (watchdog counter plus sticky flag), instantiated only under `MEM_TIMEOUT_EN`.
- Data latches use the existing `register` module or inline flops.

## Test plan
- **Direct read:** `read_b`=1, `address_b`=16'h3000, memory answers `mem_rdata`=16'hBEEF with k=2.
  - `mem_read`/`mem_address`=3000 for 3 cycles.
  - `resp_b` one cycle later with `rdata_b`=BEEF.
- **Direct write:** `write_b`=1, addr 16'h4001, `wdata_b`=16'h00AB, `wmask_b`=2'b10.
  - `mem_write`=1 with exactly those values until `mem_resp`.
  - `resp_b` pulse follows.
- **LDI:** addr 16'h1000; memory returns 16'h2000 for 1000, then 16'h1234 for 2000.
  - Two reads occur in order.
  - `rdata_b`=1234.
  - `resp_b` at minimum 3 cycles with k=0.
- **STI:** addr 16'h1000 returns pointer 16'h2002; data 16'h5555.
  - Pointer read first, then `mem_write` to 2002 with 5555.
- **Reset mid-ACCESS:** drop `rst_n` while `mem_read`=1.
  - Next cycle all outputs are 0 and no `resp_b` is produced.
  - A fresh request afterwards completes normally.
- **With `MEM_TIMEOUT_EN`:** `TIMEOUT_CYCLES`=4, memory never responds.
  - `timeout_err` rises after 4 ACCESS cycles.
  - `resp_b` pulses with `rdata_b`=0.
  - `timeout_err` stays 1 until reset.
